// File: rtl/shift_operand_issue.sv
// shift_operand_issue: registered operand-issue stage feeding the 32-bit
// logical right shifter. Operand pairs arrive over valid/ready, are held in
// a two-entry skid buffer (main + skid) and leave in FIFO order. Negative
// shift amounts are replaced by CLAMP at push time so the shifter returns 0.
//
// Optional build macro: SHIFT_ISSUE_STATS_EN
//   When defined, adds ISSUE_CNT (pops) and STALL_CNT (cycles with IN_VALID
//   high while IN_READY is low), both 16-bit saturating counters.
module shift_operand_issue #(
  parameter int               W     = 32,
  parameter int               TAG_W = 4,
  parameter logic [W-1:0]     CLAMP = 32'h000000ff
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [W-1:0]     IN_X,
  input  logic [W-1:0]     IN_Y,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [W-1:0]     OUT_X,
  output logic [W-1:0]     OUT_Y,
  output logic [TAG_W-1:0] OUT_TAG
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0]      ISSUE_CNT,
  output logic [15:0]      STALL_CNT
`endif
);

  // Occupancy of the buffer: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // A negative amount (sign bit set) becomes CLAMP; anything else passes,
  // including large positive amounts which the shifter itself handles.
  function automatic logic [W-1:0] sanitise_amount(input logic [W-1:0] amt);
    logic [W-1:0] res;
    if (amt[W-1]) begin
      res = CLAMP;
    end else begin
      res = amt;
    end
    return res;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               in_ready_nxt_s;
  logic               out_valid_nxt_s;

  logic [W-1:0]       main_x_r;
  logic [W-1:0]       main_y_r;
  logic [TAG_W-1:0]   main_tag_r;
  logic [W-1:0]       skid_x_r;
  logic [W-1:0]       skid_y_r;
  logic [TAG_W-1:0]   skid_tag_r;

  logic               push_s;
  logic               pop_s;
  logic [W-1:0]       in_y_san_s;

  logic               load_main_new_s;
  logic               load_main_skid_s;
  logic               load_skid_s;

  // Handshake qualifiers use only the registered ready/valid flags, so no
  // combinational path reaches IN_READY or OUT_VALID.
  assign push_s     = IN_VALID & in_ready_r;
  assign pop_s      = out_valid_r & OUT_READY;
  assign in_y_san_s = sanitise_amount(IN_Y);

  // State register plus registered decode of the handshake flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Next-state logic: occupancy follows push/pop on each edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && !pop_s) begin
          state_nxt_s = ST_FULL;
        end else if (pop_s && !push_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output decode: storage load controls and the next ready/valid flags.
  always_comb begin
    load_main_new_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        load_main_new_s = push_s;
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          load_main_new_s = 1'b1;
        end else if (push_s) begin
          load_skid_s = 1'b1;
        end else begin
          load_main_new_s = 1'b0;
        end
      end
      ST_FULL: begin
        load_main_skid_s = pop_s;
      end
      default: begin
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
      end
    endcase
    in_ready_nxt_s  = (state_nxt_s != ST_FULL);
    out_valid_nxt_s = (state_nxt_s != ST_EMPTY);
  end

  // Main register: takes the incoming pair or the skid entry; holds otherwise
  // so OUT_* stay stable while the consumer stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_x_r   <= '0;
      main_y_r   <= '0;
      main_tag_r <= '0;
    end else if (load_main_new_s) begin
      main_x_r   <= IN_X;
      main_y_r   <= in_y_san_s;
      main_tag_r <= IN_TAG;
    end else if (load_main_skid_s) begin
      main_x_r   <= skid_x_r;
      main_y_r   <= skid_y_r;
      main_tag_r <= skid_tag_r;
    end else begin
      main_x_r   <= main_x_r;
      main_y_r   <= main_y_r;
      main_tag_r <= main_tag_r;
    end
  end

  // Skid register: catches the second entry when main is occupied and not
  // draining this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      skid_x_r   <= '0;
      skid_y_r   <= '0;
      skid_tag_r <= '0;
    end else if (load_skid_s) begin
      skid_x_r   <= IN_X;
      skid_y_r   <= in_y_san_s;
      skid_tag_r <= IN_TAG;
    end else begin
      skid_x_r   <= skid_x_r;
      skid_y_r   <= skid_y_r;
      skid_tag_r <= skid_tag_r;
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_X     = main_x_r;
  assign OUT_Y     = main_y_r;
  assign OUT_TAG   = main_tag_r;

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] issue_cnt_r;
  logic [15:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = IN_VALID & ~in_ready_r;

  // Issue counter: one per pop, saturating at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      issue_cnt_r <= 16'h0000;
    end else if (pop_s && (issue_cnt_r != 16'hffff)) begin
      issue_cnt_r <= issue_cnt_r + 16'h0001;
    end else begin
      issue_cnt_r <= issue_cnt_r;
    end
  end

  // Stall counter: one per cycle the producer is held off, saturating.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hffff)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ISSUE_CNT = issue_cnt_r;
  assign STALL_CNT = stall_cnt_r;
`endif

endmodule

// File: tb/tb_shift_operand_issue.sv
// Self-checking bench for shift_operand_issue. A queue-based reference model
// (at most two entries, FIFO order, sign-bit clamp) predicts the outputs.
module tb_shift_operand_issue;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  tag;
  } ent_t;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_X;
  logic [31:0] IN_Y;
  logic [3:0]  IN_TAG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_X;
  logic [31:0] OUT_Y;
  logic [3:0]  OUT_TAG;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] ISSUE_CNT;
  logic [15:0] STALL_CNT;
`endif

  int   n_cmp;
  int   n_err;
  ent_t mq[$];
  logic [3:0] obs_tags[$];
  int   m_issue;
  int   m_stall;

  shift_operand_issue dut (
`ifdef SHIFT_ISSUE_STATS_EN
    .ISSUE_CNT (ISSUE_CNT),
    .STALL_CNT (STALL_CNT),
`endif
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_X      (IN_X),
    .IN_Y      (IN_Y),
    .IN_TAG    (IN_TAG),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_X     (OUT_X),
    .OUT_Y     (OUT_Y),
    .OUT_TAG   (OUT_TAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and update the reference model with the inputs
  // that were present at that edge.
  task automatic tick();
    bit   do_pop;
    bit   do_push;
    bit   do_stall;
    ent_t e;
    do_pop   = RST_N && (mq.size() > 0) && OUT_READY;
    do_push  = RST_N && IN_VALID && (mq.size() < 2);
    do_stall = RST_N && IN_VALID && (mq.size() == 2);
    e.x   = IN_X;
    e.y   = IN_Y[31] ? 32'h000000ff : IN_Y;
    e.tag = IN_TAG;
    if (do_pop) obs_tags.push_back(OUT_TAG);
    @(posedge CLK);
    if (!RST_N) begin
      mq.delete();
      m_issue = 0;
      m_stall = 0;
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_issue < 65535) m_issue++;
      end
      if (do_push) mq.push_back(e);
      if (do_stall && m_stall < 65535) m_stall++;
    end
    #1;
  endtask

  task automatic drive_idle();
    IN_VALID  = 1'b0;
    IN_X      = 32'h0;
    IN_Y      = 32'h0;
    IN_TAG    = 4'h0;
    OUT_READY = 1'b0;
  endtask

  task automatic reset_dut();
    drive_idle();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    obs_tags.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    RST_N = 1'b0;
    #12;
    n_cmp++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags: got valid=%b ready=%b expected valid=0 ready=1", OUT_VALID, IN_READY);
    end
    n_cmp++;
    if (OUT_X !== 32'h0 || OUT_Y !== 32'h0 || OUT_TAG !== 4'h0) begin
      n_err++;
      $display("FAIL reset_data: got x=%h y=%h tag=%h expected all zero", OUT_X, OUT_Y, OUT_TAG);
    end
    // A push offered during reset must be dropped.
    IN_VALID = 1'b1;
    IN_X     = 32'h12345678;
    IN_Y     = 32'h3;
    IN_TAG   = 4'h9;
    tick();
    IN_VALID = 1'b0;
    RST_N    = 1'b1;
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL reset_push_dropped: got valid=%b expected 0", OUT_VALID);
    end
  endtask

  task automatic test_single_push();
    reset_dut();
    IN_VALID = 1'b1;
    IN_X     = 32'h80000000;
    IN_Y     = 32'd4;
    IN_TAG   = 4'd3;
    tick();
    IN_VALID = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_X !== 32'h80000000 || OUT_Y !== 32'd4 || OUT_TAG !== 4'd3) begin
        n_err++;
        $display("FAIL single_hold[%0d]: got v=%b x=%h y=%h tag=%h expected v=1 x=80000000 y=4 tag=3",
                 c, OUT_VALID, OUT_X, OUT_Y, OUT_TAG);
      end
      if (c < 5) tick();
    end
    OUT_READY = 1'b1;
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got valid=%b expected 0", OUT_VALID);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] ys [4];
    logic [31:0] exp_y [4];
    ys[0] = 32'hfffffffe; exp_y[0] = 32'h000000ff;
    ys[1] = 32'd40;       exp_y[1] = 32'd40;
    ys[2] = 32'h80000000; exp_y[2] = 32'h000000ff;
    ys[3] = 32'h7fffffff; exp_y[3] = 32'h7fffffff;
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      IN_X     = $urandom;
      IN_Y     = ys[i];
      IN_TAG   = 4'(i);
      tick();
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_Y !== exp_y[i] || OUT_X !== IN_X) begin
        n_err++;
        $display("FAIL clamp[%0d]: got v=%b y=%h x=%h expected v=1 y=%h x=%h",
                 i, OUT_VALID, OUT_Y, OUT_X, exp_y[i], IN_X);
      end
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    OUT_READY = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      IN_VALID = 1'b1;
      IN_X     = 32'(t * 16);
      IN_Y     = 32'(t);
      IN_TAG   = 4'(t);
      tick();
      n_cmp++;
      if (IN_READY !== (t == 1 ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL bp_ready_after_push%0d: got %b expected %b", t, IN_READY, (t == 1 ? 1'b1 : 1'b0));
      end
    end
    IN_X   = 32'd48;
    IN_Y   = 32'd3;
    IN_TAG = 4'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (IN_READY !== 1'b0 || OUT_TAG !== 4'd1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ready=%b tag=%h expected ready=0 tag=1", c, IN_READY, OUT_TAG);
      end
    end
    OUT_READY = 1'b1;
    for (int c = 0; c < 8 && obs_tags.size() < 3; c++) begin
      if (IN_VALID && IN_READY) begin
        tick();
        IN_VALID = 1'b0;
      end else begin
        tick();
      end
    end
    IN_VALID = 1'b0;
    tick();
    n_cmp++;
    if (obs_tags.size() != 3) begin
      n_err++;
      $display("FAIL bp_pop_count: got %0d expected 3", obs_tags.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_tags[i] !== 4'(i + 1)) begin
          n_err++;
          $display("FAIL bp_order[%0d]: got %h expected %h", i, obs_tags[i], 4'(i + 1));
        end
      end
    end
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty_after: got valid=%b expected 0", OUT_VALID);
    end
`ifdef SHIFT_ISSUE_STATS_EN
    n_cmp++;
    if (ISSUE_CNT !== 16'd3 || STALL_CNT !== 16'(m_stall)) begin
      n_err++;
      $display("FAIL bp_stats: got issue=%0d stall=%0d expected issue=3 stall=%0d", ISSUE_CNT, STALL_CNT, m_stall);
    end
`endif
  endtask

  task automatic test_streaming();
    reset_dut();
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1;
      IN_X     = $urandom;
      IN_Y     = $urandom_range(0, 40);
      IN_TAG   = 4'(i);
      tick();
      n_cmp++;
      if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1 || OUT_TAG !== 4'(i)) begin
        n_err++;
        $display("FAIL stream[%0d]: got ready=%b valid=%b tag=%h expected ready=1 valid=1 tag=%h",
                 i, IN_READY, OUT_VALID, OUT_TAG, 4'(i));
      end
    end
    IN_VALID = 1'b0;
    tick();
    n_cmp++;
    if (OUT_VALID !== 1'b0 || obs_tags.size() != 16) begin
      n_err++;
      $display("FAIL stream_end: got valid=%b pops=%0d expected valid=0 pops=16", OUT_VALID, obs_tags.size());
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      IN_X      = $urandom;
      IN_Y      = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63));
      IN_TAG    = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (OUT_VALID !== (mq.size() > 0) || IN_READY !== (mq.size() < 2)) begin
        n_err++;
        $display("FAIL rand_flags[%0d]: got valid=%b ready=%b expected occupancy %0d", c, OUT_VALID, IN_READY, mq.size());
      end else if (mq.size() > 0) begin
        if (OUT_X !== mq[0].x || OUT_Y !== mq[0].y || OUT_TAG !== mq[0].tag) begin
          n_err++;
          $display("FAIL rand_data[%0d]: got x=%h y=%h tag=%h expected x=%h y=%h tag=%h",
                   c, OUT_X, OUT_Y, OUT_TAG, mq[0].x, mq[0].y, mq[0].tag);
        end
      end
`ifdef SHIFT_ISSUE_STATS_EN
      if (ISSUE_CNT !== 16'(m_issue) || STALL_CNT !== 16'(m_stall)) begin
        n_err++;
        $display("FAIL rand_stats[%0d]: got issue=%0d stall=%0d expected issue=%0d stall=%0d",
                 c, ISSUE_CNT, STALL_CNT, m_issue, m_stall);
      end
`endif
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    reset_dut();
    OUT_READY = 1'b0;
    for (int t = 0; t < 2; t++) begin
      IN_VALID = 1'b1;
      IN_X     = $urandom;
      IN_Y     = 32'(t + 1);
      IN_TAG   = 4'(t + 5);
      tick();
    end
    n_cmp++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL areset_prefull: got ready=%b valid=%b expected ready=0 valid=1", IN_READY, OUT_VALID);
    end
    #2;
    RST_N = 1'b0;
    #1;
    mq.delete();
    m_issue = 0;
    m_stall = 0;
    n_cmp++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || OUT_X !== 32'h0 || OUT_TAG !== 4'h0) begin
      n_err++;
      $display("FAIL areset_immediate: got valid=%b ready=%b x=%h tag=%h expected 0 1 0 0",
               OUT_VALID, IN_READY, OUT_X, OUT_TAG);
    end
    #2;
    RST_N     = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    obs_tags.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (OUT_VALID !== 1'b0 || obs_tags.size() != 0) begin
        n_err++;
        $display("FAIL areset_no_stale[%0d]: got valid=%b pops=%0d expected valid=0 pops=0", c, OUT_VALID, obs_tags.size());
      end
    end
  endtask

`ifdef SHIFT_ISSUE_STATS_EN
  task automatic test_stats_saturation();
    reset_dut();
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    for (int c = 0; c < 70002; c++) begin
      IN_TAG = 4'(c);
      tick();
    end
    drive_idle();
    n_cmp++;
    if (ISSUE_CNT !== 16'hffff) begin
      n_err++;
      $display("FAIL stats_saturate: got %h expected ffff", ISSUE_CNT);
    end
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    m_issue = 0;
    m_stall = 0;
    test_reset();
    test_single_push();
    test_clamp();
    test_backpressure();
    test_streaming();
    test_random();
    test_async_reset();
`ifdef SHIFT_ISSUE_STATS_EN
    test_stats_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
